// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout
//   Display-side reader of the SRAM frame buffer. It generates 640x480@60 VGA
//   timing, fetches one 16-bit pixel word per visible pixel of the first
//   FB_ROWS rows, and drives RGB and sync to the DAC. O_VIDEO_ON marks the
//   cycles in which this block owns the SRAM port.
//
// Ports
//   I_CLK          pixel clock
//   I_RST_N        asynchronous reset, active-low
//   I_SRAM_DATA    SRAM read data, valid READ_LAT cycles after the address
//   O_SRAM_ADDR    pixel word address (row*H_ACTIVE + col), held between reads
//   O_SRAM_READ    read strobe, one word per cycle
//   O_VIDEO_ON     scanout owns the SRAM port this cycle
//   O_VGA_R/G/B    pixel colour, black outside fetched pixels
//   O_VGA_HS/VS    horizontal / vertical sync, active-low
//   O_VGA_BLANK_N  low outside the visible area
//   O_FRAME_START  high while the raw counters sit at (0,0)
module vga_fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_ROWS  = 400,
  parameter int READ_LAT = 2
) (
  input  logic        I_CLK,
  input  logic        I_RST_N,
  input  logic [15:0] I_SRAM_DATA,
  output logic [17:0] O_SRAM_ADDR,
  output logic        O_SRAM_READ,
  output logic        O_VIDEO_ON,
  output logic [3:0]  O_VGA_R,
  output logic [3:0]  O_VGA_G,
  output logic [3:0]  O_VGA_B,
  output logic        O_VGA_HS,
  output logic        O_VGA_VS,
  output logic        O_VGA_BLANK_N,
  output logic        O_FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PIPE    = READ_LAT + 1;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] FB_LIM   = 10'(FB_ROWS);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0]  hcnt, vcnt;
  logic        act_raw, fetch_raw, hs_n_raw, vs_n_raw, fs_raw;
  logic [17:0] v_ext, h_ext, addr_raw;
  logic [PIPE-1:0] act_p, fetch_p, hs_p, vs_p;
  logic        unused_data_lsbs;

  // Raster counters; h and v wrap together on the last pixel of the frame.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  assign act_raw   = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign fetch_raw = act_raw && (vcnt < FB_LIM);
  assign hs_n_raw  = !((hcnt >= HS_FIRST) && (hcnt <= HS_LAST));
  assign vs_n_raw  = !((vcnt >= VS_FIRST) && (vcnt <= VS_LAST));
  assign fs_raw    = (hcnt == '0) && (vcnt == '0);

  assign v_ext = {8'd0, vcnt};
  assign h_ext = {8'd0, hcnt};

  // 640 = 512 + 128, so the row offset is two shifts and an add.
  if (H_ACTIVE == 640) begin : g_addr_shift
    assign addr_raw = (v_ext << 9) + (v_ext << 7) + h_ext;
  end else begin : g_addr_mul
    assign addr_raw = v_ext * 18'(H_ACTIVE) + h_ext;
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      O_SRAM_READ <= 1'b0;
      O_VIDEO_ON  <= 1'b0;
      O_SRAM_ADDR <= '0;
    end else begin
      O_SRAM_READ <= fetch_raw;
      O_VIDEO_ON  <= fetch_raw;
      if (fetch_raw) O_SRAM_ADDR <= addr_raw;
    end
  end

  // Delay decode by READ_LAT+1: one cycle for the address register plus the
  // SRAM latency, so each data word meets its own sync and blank.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      act_p   <= '0;
      fetch_p <= '0;
      hs_p    <= '1;
      vs_p    <= '1;
    end else begin
      act_p   <= {act_p[PIPE-2:0],   act_raw};
      fetch_p <= {fetch_p[PIPE-2:0], fetch_raw};
      hs_p    <= {hs_p[PIPE-2:0],    hs_n_raw};
      vs_p    <= {vs_p[PIPE-2:0],    vs_n_raw};
    end
  end

  assign O_VGA_BLANK_N = act_p[PIPE-1];
  assign O_VGA_HS      = hs_p[PIPE-1];
  assign O_VGA_VS      = vs_p[PIPE-1];

  // Gating on the delayed fetch flag discards data from reads aborted by reset
  // and keeps unfetched rows and blanking black.
  assign O_VGA_R = fetch_p[PIPE-1] ? I_SRAM_DATA[15:12] : 4'd0;
  assign O_VGA_G = fetch_p[PIPE-1] ? I_SRAM_DATA[11:8]  : 4'd0;
  assign O_VGA_B = fetch_p[PIPE-1] ? I_SRAM_DATA[7:4]   : 4'd0;

  // Frame start tracks the raw counters so the writer side sees the frame
  // boundary immediately; forced low while reset is held.
  assign O_FRAME_START = fs_raw & I_RST_N;

  assign unused_data_lsbs = ^I_SRAM_DATA[3:0];

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: three instances (READ_LAT 2, 1, 4) with a reduced
// vertical raster share one clock. A scoreboard queue per instance holds the
// expected aligned video word for each raw counter position.
module tb_vga_fb_scanout;

  localparam int VA  = 20;
  localparam int VFP = 2;
  localparam int VSY = 2;
  localparam int VBP = 3;
  localparam int FBR = 12;
  localparam int HT  = 800;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int F   = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] data [3];
  logic [17:0] addr [3];
  logic        rd [3], vo [3], hs [3], vs [3], bl [3], fs [3];
  logic [3:0]  r [3], g [3], b [3];

  for (genvar d = 0; d < 3; d++) begin : g_dut
    localparam int L = (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    logic [15:0] sram_pipe [L];

    vga_fb_scanout #(
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .FB_ROWS(FBR), .READ_LAT(L)
    ) u_dut (
      .I_CLK(clk), .I_RST_N(rst_n), .I_SRAM_DATA(data[d]),
      .O_SRAM_ADDR(addr[d]), .O_SRAM_READ(rd[d]), .O_VIDEO_ON(vo[d]),
      .O_VGA_R(r[d]), .O_VGA_G(g[d]), .O_VGA_B(b[d]),
      .O_VGA_HS(hs[d]), .O_VGA_VS(vs[d]), .O_VGA_BLANK_N(bl[d]),
      .O_FRAME_START(fs[d])
    );

    // SRAM returns data = addr[15:0]; idle cycles return all-ones so that
    // ungated data would show up as colour.
    always_ff @(posedge clk) begin
      sram_pipe[0] <= rd[d] ? addr[d][15:0] : 16'hFFFF;
      for (int i = 1; i < L; i++) sram_pipe[i] <= sram_pipe[i-1];
    end
    assign data[d] = sram_pipe[L-1];
  end

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;
  int mh, mv, cyc;
  logic        pf;
  logic [17:0] pa;
  int rd_cnt, hs_lo, vs_lo, fs_cnt;
  logic [14:0] q0 [$];
  logic [14:0] q1 [$];
  logic [14:0] q2 [$];

  function automatic int lat(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  task automatic check(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
    end
  endtask

  function automatic logic is_fetch(input int h, input int v);
    return (h < 640) && (v < VA) && (v < FBR);
  endfunction

  function automatic logic [14:0] exp_vid(input int h, input int v);
    logic        act, hsn, vsn;
    logic [15:0] pix;
    logic [11:0] rgb;
    act = (h < 640) && (v < VA);
    hsn = !((h >= 656) && (h <= 751));
    vsn = !((v >= VA + VFP) && (v <= VA + VFP + VSY - 1));
    pix = 16'(v * 640 + h);
    rgb = is_fetch(h, v) ? {pix[15:12], pix[11:8], pix[7:4]} : 12'h000;
    return {act, hsn, vsn, rgb};
  endfunction

  task automatic reset_model();
    mh = 0; mv = 0; cyc = 0; pf = 1'b0; pa = '0;
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < lat(0) + 1; i++) q0.push_back(15'h3000);
    for (int i = 0; i < lat(1) + 1; i++) q1.push_back(15'h3000);
    for (int i = 0; i < lat(2) + 1; i++) q2.push_back(15'h3000);
  endtask

  task automatic chk_reset();
    for (int d = 0; d < 3; d++) begin
      check("rst_addr", d, 32'(addr[d]), 32'd0);
      check("rst_ctl", d, 32'({rd[d], vo[d], bl[d], hs[d], vs[d], fs[d], r[d], g[d], b[d]}),
            32'({6'b000110, 12'h000}));
    end
  endtask

  task automatic check_cycle();
    logic [14:0] e_new, e;
    e_new = exp_vid(mh, mv);
    for (int d = 0; d < 3; d++) begin
      check("frame_start", d, 32'(fs[d]), 32'((mh == 0) && (mv == 0)));
      check("sram_read", d, 32'(rd[d]), 32'(pf));
      check("video_on", d, 32'(vo[d]), 32'(pf));
      check("sram_addr", d, 32'(addr[d]), 32'(pa));
      case (d)
        0: begin q0.push_back(e_new); e = q0.pop_front(); end
        1: begin q1.push_back(e_new); e = q1.pop_front(); end
        default: begin q2.push_back(e_new); e = q2.pop_front(); end
      endcase
      check("video", d, 32'({bl[d], hs[d], vs[d], r[d], g[d], b[d]}), 32'(e));
      if (cyc == 3 * HT + 5 + lat(d) + 1)
        check("px_c5_r3", d, 32'({r[d], g[d], b[d]}), 32'h078);
    end
    if (cyc < F) begin
      rd_cnt += int'(rd[0]);
      hs_lo  += int'(!hs[0]);
      vs_lo  += int'(!vs[0]);
      fs_cnt += int'(fs[0]);
    end
    pf = is_fetch(mh, mv);
    if (pf) pa = 18'(mv * 640 + mh);
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end
    cyc++;
  endtask

  initial begin
    int guard;
    rd_cnt = 0; hs_lo = 0; vs_lo = 0; fs_cnt = 0;

    // Reset held from time zero.
    repeat (3) @(negedge clk);
    cyc = -1;
    chk_reset();

    // Release and run one frame plus a margin past the wrap.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    reset_model();
    check_cycle();
    repeat (F + 49) begin
      @(negedge clk);
      check_cycle();
    end
    check("t2_reads", 0, 32'(rd_cnt), 32'(FBR * 640));
    check("t2_hs_low", 0, 32'(hs_lo), 32'(96 * VT));
    check("t2_vs_low", 0, 32'(vs_lo), 32'(VSY * HT));
    check("t2_fs_count", 0, 32'(fs_cnt), 32'd1);

    // Advance to (h=300, v=5) and reset mid-line.
    guard = 0;
    while (!((mh == 300) && (mv == 5)) && (guard < F)) begin
      @(negedge clk);
      check_cycle();
      guard++;
    end
    @(negedge clk);
    check_cycle();
    rst_n = 1'b0;
    #1;
    chk_reset();
    repeat (3) begin
      @(negedge clk);
      chk_reset();
    end

    // Restart: counting resumes at (0,0) with an empty pipeline.
    rst_n = 1'b1;
    #1;
    reset_model();
    check_cycle();
    repeat (4 * HT + 20) begin
      @(negedge clk);
      check_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
